// File: rtl/ram_debug_loader_if.sv
// Host byte-stream link between a host transport (for example a UART
// receiver/transmitter pair) and the debug RAM loader.
//   In_Data/In_Valid/In_Ready    : host -> loader command and payload bytes
//   Out_Data/Out_Valid/Out_Ready : loader -> host response bytes
// modport slave  : the loader side
// modport master : the host side
interface ram_debug_loader_if;
  logic [7:0] In_Data;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic       Out_Ready;

  modport slave (
    input  In_Data, In_Valid, Out_Ready,
    output In_Ready, Out_Data, Out_Valid
  );

  modport master (
    output In_Data, In_Valid, Out_Ready,
    input  In_Ready, Out_Data, Out_Valid
  );
endinterface

// File: rtl/ram_debug_loader.sv
// Byte-protocol front end for the RV32Core debug RAM ports. Host commands
// fill DataRAM/InstRAM through the A2/WD2/WE2 debug port ('W'), dump RAM
// words back as little-endian bytes ('D'), or pulse the core reset ('G').
// Ports:
//   CPU_CLK, CPU_RST        : clock, synchronous active-high block reset
//   host                    : byte stream in/out (ram_debug_loader_if.slave)
//   Core_Rst                : drives the core's reset
//   CPU_Debug_*RAM_A2/WD2/WE2/RD2 : debug port of each RAM
//   Busy                    : high whenever the FSM is not idle
//   Err                     : sticky protocol error, cleared by CPU_RST
module ram_debug_loader #(
  parameter int BRAMWORDS    = 4096,
  parameter int READ_LATENCY = 2,
  parameter int RST_CYCLES   = 5
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  ram_debug_loader_if.slave host,
  output logic        Core_Rst,
  output logic [31:0] CPU_Debug_DataRAM_A2,
  output logic [31:0] CPU_Debug_DataRAM_WD2,
  output logic [3:0]  CPU_Debug_DataRAM_WE2,
  input  logic [31:0] CPU_Debug_DataRAM_RD2,
  output logic [31:0] CPU_Debug_InstRAM_A2,
  output logic [31:0] CPU_Debug_InstRAM_WD2,
  output logic [3:0]  CPU_Debug_InstRAM_WE2,
  input  logic [31:0] CPU_Debug_InstRAM_RD2,
  output logic        Busy,
  output logic        Err
);

  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_DUMP  = 8'h44;
  localparam logic [7:0]  CMD_GO    = 8'h47;
  localparam logic [7:0]  ACK_BYTE  = 8'h4B;
  localparam logic [31:0] ADDR_LAST = 32'((BRAMWORDS - 1) * 4);
  localparam logic [15:0] WAIT_LAST = 16'(READ_LATENCY - 1);
  localparam logic [15:0] HOLD_LAST = 16'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, TGT, CNT_H, CNT_L, WR_BYTE, WR_COMMIT,
    RD_ISSUE, RD_WAIT, RD_SEND, RST_HOLD, ACK
  } state_t;

  state_t      state, stateNext;
  logic        live, isWrite, tgtInst, outValid, err;
  logic [7:0]  outData, cntHi;
  logic [15:0] remaining, waitCnt;
  logic [31:0] addr, addrNext, wordBuf, rdShift, rdWord;
  logic [1:0]  byteIdx;
  logic        accept, outFire, cntZero, cmdValid, tgtValid, lastWord;

  // live holds In_Ready low during reset and for the first cycle after it.
  assign host.In_Ready  = live && (state inside {IDLE, TGT, CNT_H, CNT_L, WR_BYTE});
  assign host.Out_Valid = outValid;
  assign host.Out_Data  = outData;
  assign accept   = host.In_Valid && host.In_Ready;
  assign outFire  = outValid && host.Out_Ready;
  assign cntZero  = ({cntHi, host.In_Data} == 16'd0);
  assign cmdValid = host.In_Data inside {CMD_WRITE, CMD_DUMP, CMD_GO};
  assign tgtValid = (host.In_Data[7:1] == 7'd0);
  assign lastWord = (remaining == 16'd1);
  assign addrNext = (addr == ADDR_LAST) ? 32'd0 : addr + 32'd4;
  assign rdWord   = tgtInst ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;
  assign Core_Rst = (state == RST_HOLD);
  assign Busy     = (state != IDLE);
  assign Err      = err;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) begin
        if (host.In_Data == CMD_WRITE || host.In_Data == CMD_DUMP) stateNext = TGT;
        else if (host.In_Data == CMD_GO)                           stateNext = RST_HOLD;
      end
      TGT:       if (accept) stateNext = tgtValid ? CNT_H : IDLE;
      CNT_H:     if (accept) stateNext = CNT_L;
      CNT_L:     if (accept) begin
        if (isWrite) stateNext = cntZero ? ACK : WR_BYTE;
        else         stateNext = cntZero ? IDLE : RD_ISSUE;
      end
      WR_BYTE:   if (accept && byteIdx == 2'd3) stateNext = WR_COMMIT;
      WR_COMMIT: stateNext = lastWord ? ACK : WR_BYTE;
      RD_ISSUE:  stateNext = RD_WAIT;
      RD_WAIT:   if (waitCnt == WAIT_LAST) stateNext = RD_SEND;
      RD_SEND:   if (outFire && byteIdx == 2'd3) stateNext = lastWord ? IDLE : RD_ISSUE;
      RST_HOLD:  if (waitCnt == HOLD_LAST) stateNext = ACK;
      ACK:       if (outFire) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // Only the selected RAM sees address/strobe activity; WD2 only carries
  // data during the commit cycle.
  always_comb begin
    CPU_Debug_DataRAM_A2  = '0;
    CPU_Debug_DataRAM_WD2 = '0;
    CPU_Debug_DataRAM_WE2 = '0;
    CPU_Debug_InstRAM_A2  = '0;
    CPU_Debug_InstRAM_WD2 = '0;
    CPU_Debug_InstRAM_WE2 = '0;
    if (state inside {WR_COMMIT, RD_ISSUE, RD_WAIT}) begin
      if (tgtInst) CPU_Debug_InstRAM_A2 = addr;
      else         CPU_Debug_DataRAM_A2 = addr;
    end
    if (state == WR_COMMIT) begin
      if (tgtInst) begin
        CPU_Debug_InstRAM_WD2 = wordBuf;
        CPU_Debug_InstRAM_WE2 = 4'b1111;
      end else begin
        CPU_Debug_DataRAM_WD2 = wordBuf;
        CPU_Debug_DataRAM_WE2 = 4'b1111;
      end
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      live      <= 1'b0;
      isWrite   <= 1'b0;
      tgtInst   <= 1'b0;
      outValid  <= 1'b0;
      outData   <= '0;
      err       <= 1'b0;
      cntHi     <= '0;
      remaining <= '0;
      waitCnt   <= '0;
      addr      <= '0;
      byteIdx   <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          isWrite <= (host.In_Data == CMD_WRITE);
          addr    <= '0;
          byteIdx <= '0;
          waitCnt <= '0;
          if (!cmdValid) err <= 1'b1;
        end
        TGT: if (accept) begin
          tgtInst <= host.In_Data[0];
          if (!tgtValid) err <= 1'b1;
        end
        CNT_H: if (accept) cntHi <= host.In_Data;
        CNT_L: if (accept) begin
          remaining <= {cntHi, host.In_Data};
          if (isWrite && cntZero) begin
            outValid <= 1'b1;
            outData  <= ACK_BYTE;
          end
        end
        WR_BYTE: if (accept) byteIdx <= byteIdx + 2'd1;
        WR_COMMIT: begin
          remaining <= remaining - 16'd1;
          addr      <= addrNext;
          if (lastWord) begin
            outValid <= 1'b1;
            outData  <= ACK_BYTE;
          end
        end
        RD_ISSUE: waitCnt <= '0;
        // Capture edge: the first byte is registered together with the word.
        RD_WAIT: begin
          waitCnt <= waitCnt + 16'd1;
          if (waitCnt == WAIT_LAST) begin
            outValid <= 1'b1;
            outData  <= rdWord[7:0];
            byteIdx  <= '0;
          end
        end
        RD_SEND: if (outFire) begin
          byteIdx <= byteIdx + 2'd1;
          if (byteIdx == 2'd3) begin
            outValid  <= 1'b0;
            remaining <= remaining - 16'd1;
            addr      <= addrNext;
          end else begin
            outData <= rdShift[15:8];
          end
        end
        RST_HOLD: begin
          waitCnt <= waitCnt + 16'd1;
          if (waitCnt == HOLD_LAST) begin
            outValid <= 1'b1;
            outData  <= ACK_BYTE;
          end
        end
        ACK: if (outFire) outValid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Word assembly and read shift register carry data only; stale contents
  // after a reset are always fully overwritten before use.
  always_ff @(posedge CPU_CLK) begin
    if (state == WR_BYTE && accept) wordBuf <= {host.In_Data, wordBuf[31:8]};
    if (state == RD_WAIT && waitCnt == WAIT_LAST) rdShift <= rdWord;
    else if (state == RD_SEND && outFire)         rdShift <= {8'd0, rdShift[31:8]};
  end

endmodule
